// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: shares one registered valid/ready output stream among
// NUM_IN input streams. Arbitration is round-robin at packet granularity:
// once a requester's first beat is taken, it keeps the grant until its
// last beat has been accepted. out_id tells downstream which requester
// supplied each beat.

module stream_rr_arbiter #(
    parameter int  NUM_IN     = 4,
    parameter int  DATA_WIDTH = 256,
    localparam int ID_WIDTH   = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_last,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [ID_WIDTH-1:0]          out_id,
    input  logic                         out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   grant_q;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   sel;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic [ID_WIDTH-1:0]   hi_sel;
    logic [ID_WIDTH-1:0]   lo_sel;
    logic                  hi_hit;
    logic                  lo_hit;
    logic                  sel_found;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  locked;
    logic                  load_en;
    logic                  accept;

    assign locked  = (state == LOCKED);
    // The output register may take a new beat when empty or being drained.
    assign load_en = !out_valid || out_ready;
    // Gated by reset so nothing is acknowledged while the block is held in reset.
    assign accept  = reset && sel_found && load_en;
    // Pointer moves just past the requester whose packet ends, wrapping to 0.
    assign next_ptr = (sel == ID_WIDTH'(NUM_IN - 1)) ? '0 : sel + ID_WIDTH'(1);

    // Pick the requester to serve: the lock owner, or the first valid one at or after rr_ptr (wrapping).
    always_comb begin
        hi_hit    = 1'b0;
        lo_hit    = 1'b0;
        hi_sel    = '0;
        lo_sel    = '0;
        sel       = '0;
        sel_found = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_hit = 1'b1;
                lo_sel = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= rr_ptr) begin
                    hi_hit = 1'b1;
                    hi_sel = ID_WIDTH'(i);
                end
            end
        end
        if (locked) begin
            sel       = grant_q;
            sel_found = in_valid[grant_q];
        end else if (hi_hit) begin
            sel       = hi_sel;
            sel_found = 1'b1;
        end else begin
            sel       = lo_sel;
            sel_found = lo_hit;
        end
    end

    // Route the selected requester's payload and end-of-packet flag toward the output register.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == ID_WIDTH'(i)) begin
                sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    // Acknowledge only the selected requester, and only when its beat is actually taken.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = accept && (sel == ID_WIDTH'(i));
        end
    end

    // Packet lock state machine: hold the grant mid-packet, advance the round-robin pointer at packet end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            if (sel_last) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else begin
                state   <= LOCKED;
                grant_q <= sel;
            end
        end
    end

    // Output register: load on accept, empty when drained with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed and random checks of stream_rr_arbiter
// against a transaction-level reference model and per-requester scoreboard.

module tb_stream_rr_arbiter;

    localparam int NUM_IN = 4;
    localparam int DW     = 32;

    logic                 clk;
    logic                 reset;
    logic [NUM_IN-1:0]    in_valid;
    logic [NUM_IN*DW-1:0] in_data;
    logic [NUM_IN-1:0]    in_last;
    logic [NUM_IN-1:0]    in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_last;
    logic [1:0]           out_id;
    logic                 out_ready;

    int compare_count = 0;
    int fail_count    = 0;

    // Reference model: who owns the current packet (-1 = none), where the round robin starts,
    // and what the output register should hold.
    int            m_owner = -1;
    int            m_ptr   = 0;
    logic          m_ov    = 1'b0;
    logic [DW-1:0] m_od    = '0;
    logic          m_ol    = 1'b0;
    int            m_oid   = 0;

    // Scoreboard of accepted beats per requester: {last, data}.
    logic [DW:0] sb_q[NUM_IN][$];

    // Observed packet ownership and per-requester lost arbitrations.
    int obs_owner = -1;
    int loss[NUM_IN];

    logic [DW-1:0] drv3;

    stream_rr_arbiter #(
        .NUM_IN    (NUM_IN),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compare_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [NUM_IN-1:0] v, input logic [NUM_IN-1:0] l, input logic r);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        for (int i = 0; i < NUM_IN; i++) begin
            in_data[i*DW +: DW] = $urandom();
        end
    endtask

    // One clock cycle: check handshakes before the edge, advance the model, check outputs after the edge.
    task automatic check_output();
        int win;
        int j;
        logic [NUM_IN-1:0] exp_ready;
        logic [NUM_IN-1:0] acc_obs;
        logic [DW:0]       sb_item;
        #1;
        win = -1;
        if (reset && (!m_ov || out_ready)) begin
            if (m_owner >= 0) begin
                if (in_valid[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (win < 0 && in_valid[(m_ptr + k) % NUM_IN]) win = (m_ptr + k) % NUM_IN;
                end
            end
        end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        check_val("in_ready", 64'(in_ready), 64'(exp_ready));

        if (reset && out_valid === 1'b1 && out_ready) begin
            check_val("sb_nonempty", 64'(sb_q[out_id].size() > 0), 64'(1));
            if (sb_q[out_id].size() > 0) begin
                sb_item = sb_q[out_id].pop_front();
                check_val("sb_data", 64'(out_data), 64'(sb_item[DW-1:0]));
                check_val("sb_last", 64'(out_last), 64'(sb_item[DW]));
            end
        end

        acc_obs = in_ready & in_valid;
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!in_valid[i]) loss[i] = 0;
            end
            if (acc_obs != '0) begin
                j = 0;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (acc_obs[i]) j = i;
                end
                if (obs_owner >= 0) begin
                    check_val("no_interleave", 64'(j), 64'(obs_owner));
                end else begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (i != j && in_valid[i]) begin
                            loss[i]++;
                            check_val("starve_bound", 64'(loss[i] <= 3), 64'(1));
                        end
                    end
                    loss[j] = 0;
                end
                obs_owner = in_last[j] ? -1 : j;
            end
        end

        if (!reset) begin
            m_owner   = -1;
            m_ptr     = 0;
            m_ov      = 1'b0;
            m_od      = '0;
            m_ol      = 1'b0;
            m_oid     = 0;
            obs_owner = -1;
            for (int i = 0; i < NUM_IN; i++) begin
                sb_q[i].delete();
                loss[i] = 0;
            end
        end else if (win >= 0) begin
            m_ov  = 1'b1;
            m_od  = in_data[win*DW +: DW];
            m_ol  = in_last[win];
            m_oid = win;
            sb_q[win].push_back({in_last[win], in_data[win*DW +: DW]});
            if (in_last[win]) begin
                m_owner = -1;
                m_ptr   = (win + 1) % NUM_IN;
            end else begin
                m_owner = win;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end

        @(posedge clk);
        #1;
        check_val("out_valid", 64'(out_valid), 64'(m_ov));
        check_val("out_data", 64'(out_data), 64'(m_od));
        check_val("out_last", 64'(out_last), 64'(m_ol));
        check_val("out_id", 64'(out_id), 64'(m_oid));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) loss[i] = 0;

        $display("[TB] reset with all requesters valid");
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(4'b1111, 4'b1111, 1'b1);
            #1;
            check_val("rst_in_ready", 64'(in_ready), 64'(0));
            check_output();
            check_val("rst_out_valid", 64'(out_valid), 64'(0));
        end

        $display("[TB] single-beat round robin after reset release");
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(4'b1111, 4'b1111, 1'b1);
            check_output();
            check_val("rr_valid", 64'(out_valid), 64'(1));
            check_val("rr_id", 64'(out_id), 64'(k % 4));
        end
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        check_output();
        check_val("drain_valid", 64'(out_valid), 64'(0));

        $display("[TB] packet lock with gap");
        apply_stimulus(4'b0010, 4'b0010, 1'b1);
        check_output();
        check_val("pre_id", 64'(out_id), 64'(1));
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(4'b0110, 4'b0010, 1'b1);
            #1;
            check_val("lock_ready", 64'(in_ready), 64'(4'b0100));
            check_output();
            check_val("lock_id", 64'(out_id), 64'(2));
            check_val("lock_last", 64'(out_last), 64'(0));
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(4'b0010, 4'b0010, 1'b1);
            #1;
            check_val("gap_ready", 64'(in_ready), 64'(0));
            check_output();
            check_val("gap_valid", 64'(out_valid), 64'(0));
        end
        apply_stimulus(4'b0110, 4'b0110, 1'b1);
        #1;
        check_val("end_ready", 64'(in_ready), 64'(4'b0100));
        check_output();
        check_val("end_id", 64'(out_id), 64'(2));
        check_val("end_last", 64'(out_last), 64'(1));
        apply_stimulus(4'b0010, 4'b0010, 1'b1);
        check_output();
        check_val("next_id", 64'(out_id), 64'(1));
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        check_output();

        $display("[TB] backpressure");
        apply_stimulus(4'b1111, 4'b1111, 1'b1);
        check_output();
        apply_stimulus(4'b1111, 4'b1111, 1'b1);
        drv3 = in_data[3*DW +: DW];
        check_output();
        check_val("bp_id0", 64'(out_id), 64'(3));
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'b1111, 4'b1111, 1'b0);
            #1;
            check_val("bp_ready", 64'(in_ready), 64'(0));
            check_output();
            check_val("bp_valid", 64'(out_valid), 64'(1));
            check_val("bp_id", 64'(out_id), 64'(3));
            check_val("bp_last", 64'(out_last), 64'(1));
            check_val("bp_data", 64'(out_data), 64'(drv3));
        end
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(4'b1111, 4'b1111, 1'b1);
            check_output();
            check_val("bp_resume_id", 64'(out_id), 64'(k));
        end
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        check_output();

        $display("[TB] wrap and single requester");
        apply_stimulus(4'b0100, 4'b0100, 1'b1);
        check_output();
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(4'b1001, 4'b1001, 1'b1);
            check_output();
            check_val("wrap_id", 64'(out_id), 64'(((k % 2) == 0) ? 3 : 0));
        end
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(4'b0010, 4'b0010, 1'b1);
            check_output();
            check_val("solo_valid", 64'(out_valid), 64'(1));
            check_val("solo_id", 64'(out_id), 64'(1));
        end
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        check_output();

        $display("[TB] reset mid-packet");
        apply_stimulus(4'b0001, 4'b0000, 1'b1);
        check_output();
        check_val("mid_id", 64'(out_id), 64'(0));
        reset = 1'b0;
        apply_stimulus(4'b0001, 4'b0000, 1'b1);
        #1;
        check_val("mid_rst_ready", 64'(in_ready), 64'(0));
        check_output();
        check_val("mid_rst_valid", 64'(out_valid), 64'(0));
        reset = 1'b1;
        apply_stimulus(4'b0010, 4'b0000, 1'b1);
        #1;
        check_val("post_rst_ready", 64'(in_ready), 64'(4'b0010));
        check_output();
        check_val("post_rst_id", 64'(out_id), 64'(1));
        apply_stimulus(4'b0010, 4'b0010, 1'b1);
        check_output();
        check_val("post_rst_last", 64'(out_last), 64'(1));
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        check_output();

        $display("[TB] random traffic");
        for (int n = 0; n < 10000; n++) begin
            apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            check_output();
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(4'b0000, 4'b0000, 1'b1);
            check_output();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
